// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, branch/jump redirect,
// load-use stall, plus stall/redirect statistics and a sticky memory timeout.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        mem_branch,
  input  logic        mem_zero,
  input  logic        mem_jump,
  input  logic        mem_access,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic [1:0]  pc_sel,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        mem_timeout
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t     state;
  logic [7:0] wait_cnt;

  logic freeze;
  logic redirect;
  logic load_use;
  logic stall_eff;
  logic flush_eff;

  assign freeze   = mem_access & ~dmem_ready;
  assign redirect = (mem_branch & mem_zero) | mem_jump;
  assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                    ((ex_rd == id_rs) |
                     (id_uses_rt & (ex_rd == id_rt)));

  assign stall_eff = ~rst & (freeze | (~redirect & load_use));
  assign flush_eff = ~rst & ~freeze & redirect;

  // Conditions overlap, so order encodes priority.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pc_sel      = 2'b00;
    priority case (1'b1)
      rst: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end
      freeze: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end
      redirect: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        pc_sel      = mem_jump ? 2'b10 : 2'b01;
      end
      load_use: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      stall_cnt   <= 16'd0;
      flush_cnt   <= 16'd0;
      mem_timeout <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (freeze) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd0;
          end
        end
        MEM_WAIT: begin
          if (freeze) begin
            if (wait_cnt != 8'hFF)
              wait_cnt <= wait_cnt + 8'd1;
            // Flag on the edge the count lands on 255.
            if (wait_cnt >= 8'hFE)
              mem_timeout <= 1'b1;
          end else begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end
        end
        default: state <= RUN;
      endcase
      if (stall_eff && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (flush_eff && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rt, ex_mem_read;
  logic        mem_branch, mem_zero, mem_jump;
  logic        mem_access, dmem_ready;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic [1:0]  pc_sel;
  logic [15:0] stall_cnt, flush_cnt;
  logic        mem_timeout;

  int n_chk  = 0;
  int n_fail = 0;
  int es     = 0;
  int ef     = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_jump(mem_jump), .mem_access(mem_access),
    .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .pc_sel(pc_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_timeout(mem_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [4:0] en,
                         input logic [2:0] fl, input logic [1:0] ps);
    #1;
    chk({tag, ".en"}, 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}),
        32'(en));
    chk({tag, ".fl"}, 32'({ifid_flush, idex_flush, exmem_flush}), 32'(fl));
    chk({tag, ".pcsel"}, 32'(pc_sel), 32'(ps));
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".stall"}, 32'(stall_cnt), 32'(es));
    chk({tag, ".flush"}, 32'(flush_cnt), 32'(ef));
  endtask

  task automatic chk_st(input string tag, input logic st,
                        input logic [7:0] wc);
    chk({tag, ".state"}, 32'(dut.state), 32'(st));
    chk({tag, ".wait"}, 32'(dut.wait_cnt), 32'(wc));
  endtask

  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    mem_branch = 1'b0; mem_zero = 1'b0; mem_jump = 1'b0;
    mem_access = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lu();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    lu();
    mem_access = 1'b1;
    @(negedge clk);
    chk_out("rst_out", 5'b00000, 3'b111, 2'b00);
    tick();
    tick();
    chk_cnt("rst_cnt");
    chk("rst_to", 32'(mem_timeout), 0);
    chk_st("rst_st", 1'b0, 8'd0);

    rst = 1'b0;
    idle();
    chk_out("idle", 5'b11111, 3'b000, 2'b00);
    tick();

    lu();
    chk_out("lu_rs", 5'b00111, 3'b010, 2'b00);
    tick(); es++;
    chk_cnt("lu_rs");

    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd3;
    id_rt = 5'd5; id_uses_rt = 1'b1;
    chk_out("lu_rt", 5'b00111, 3'b010, 2'b00);
    tick(); es++;

    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
    chk_out("lu_zero", 5'b11111, 3'b000, 2'b00);
    tick();

    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rt = 5'd7;
    chk_out("lu_nort", 5'b11111, 3'b000, 2'b00);
    tick();
    chk_cnt("nostall");

    idle();
    mem_branch = 1'b1; mem_zero = 1'b1;
    chk_out("br", 5'b11111, 3'b111, 2'b01);
    tick(); ef++;
    chk_cnt("br");

    mem_zero = 1'b0;
    chk_out("br_nt", 5'b11111, 3'b000, 2'b00);
    tick();

    mem_zero = 1'b1; mem_jump = 1'b1;
    chk_out("br_jmp", 5'b11111, 3'b111, 2'b10);
    tick(); ef++;

    idle();
    lu();
    mem_jump = 1'b1;
    chk_out("jmp_lu", 5'b11111, 3'b111, 2'b10);
    tick(); ef++;
    chk_cnt("jmp_lu");

    idle();
    mem_access = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_jump = (i == 1);
      chk_out("mw_frz", 5'b00000, 3'b000, 2'b00);
      tick(); es++;
      chk_st("mw_st", 1'b1, 8'(i));
    end
    mem_jump = 1'b0;
    dmem_ready = 1'b1;
    chk_out("mw_rdy", 5'b11111, 3'b000, 2'b00);
    tick();
    chk_st("mw_back", 1'b0, 8'd0);
    chk_cnt("mw");

    chk_out("zl", 5'b11111, 3'b000, 2'b00);
    tick();
    chk_st("zl", 1'b0, 8'd0);
    chk_cnt("zl");

    dmem_ready = 1'b0;
    tick(); es++;
    chk_st("drop_in", 1'b1, 8'd0);
    mem_access = 1'b0;
    chk_out("drop", 5'b11111, 3'b000, 2'b00);
    tick();
    chk_st("drop", 1'b0, 8'd0);

    mem_access = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    chk_st("to255", 1'b1, 8'd254);
    chk("to_pre", 32'(mem_timeout), 0);
    tick();
    chk_st("to256", 1'b1, 8'd255);
    chk("to_set", 32'(mem_timeout), 1);
    for (int i = 0; i < 44; i++) tick();
    es += 300;
    chk_st("to_sat", 1'b1, 8'd255);
    dmem_ready = 1'b1;
    chk_out("to_rdy", 5'b11111, 3'b000, 2'b00);
    tick();
    chk_st("to_back", 1'b0, 8'd0);
    chk("to_hold", 32'(mem_timeout), 1);
    chk_cnt("to");

    idle();
    lu();
    begin
      int n;
      n = 65535 - es;
      for (int i = 0; i < n; i++) tick();
    end
    es = 65535;
    chk_cnt("sat_pre");
    tick();
    chk_cnt("sat");

    idle();
    mem_access = 1'b1;
    tick();
    tick();
    chk_st("rw_in", 1'b1, 8'd1);
    rst = 1'b1;
    chk_out("rw_out", 5'b00000, 3'b111, 2'b00);
    tick();
    es = 0; ef = 0;
    chk_st("rw", 1'b0, 8'd0);
    chk_cnt("rw");
    chk("rw_to", 32'(mem_timeout), 0);
    rst = 1'b0;
    idle();
    tick();
    chk_cnt("post");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
